// File: rtl/irq_encoder16.sv
// Sixteen-line request encoder: captures request lines into a pending register
// and grants one pending index at a time under a valid/ack handshake.
module irq_encoder16 #(
    parameter bit EDGE = 1'b1,
    parameter bit RR   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        En,
    input  logic [15:0] req,
    input  logic        ack,
    output logic        valid,
    output logic [3:0]  id,
    output logic [15:0] pending
);
    localparam int unsigned N  = 16;
    localparam int unsigned IW = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  req_q;
    logic [N-1:0]  pending_q, pending_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] id_q, id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  cap, clr;
    logic [IW-1:0] start, idx, sel;

    // Capture new requests, retire the acknowledged one; a capture beats a clear.
    always_comb begin : capture_clear
        cap = EDGE ? (req & ~req_q) : req;
        clr = '0;
        if (valid_q && ack) begin
            clr[id_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | cap;
    end

    // Scan from the start index upward with wrap; descending loop keeps the first hit.
    always_comb begin : select
        start = RR ? ptr_q : '0;
        idx   = '0;
        sel   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            idx = start + IW'(i);
            if (pending_q[idx]) begin
                sel = idx;
            end
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (En && (pending_q != '0)) begin
                    state_d = GRANT;
                    valid_d = 1'b1;
                    id_d    = sel;
                end
            end
            GRANT: begin
                if (ack) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    if (RR) begin
                        ptr_d = id_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin : regs
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pending_q <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
        end
    end

    assign valid   = valid_q;
    assign id      = id_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_irq_encoder16.sv
// Bench for irq_encoder16: four parameter variants share stimulus; expected
// grant indices are queued when requests are driven and popped on each grant.
module tb_irq_encoder16;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        En  = 1'b1;
    logic [15:0] req = '0;
    logic        ack = 1'b0;

    logic        v_f, v_r, v_l, v_lr;
    logic [3:0]  id_f, id_r, id_l, id_lr;
    logic [15:0] p_f, p_r, p_l, p_lr;

    logic [3:0]  exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    // Edge capture, fixed priority
    irq_encoder16 #(.EDGE(1'b1), .RR(1'b0)) dut_f (
        .clk(clk), .rst(rst), .En(En), .req(req), .ack(ack),
        .valid(v_f), .id(id_f), .pending(p_f));
    // Edge capture, round-robin
    irq_encoder16 #(.EDGE(1'b1), .RR(1'b1)) dut_r (
        .clk(clk), .rst(rst), .En(En), .req(req), .ack(ack),
        .valid(v_r), .id(id_r), .pending(p_r));
    // Level capture, fixed priority
    irq_encoder16 #(.EDGE(1'b0), .RR(1'b0)) dut_l (
        .clk(clk), .rst(rst), .En(En), .req(req), .ack(ack),
        .valid(v_l), .id(id_l), .pending(p_l));
    // Level capture, round-robin
    irq_encoder16 #(.EDGE(1'b0), .RR(1'b1)) dut_lr (
        .clk(clk), .rst(rst), .En(En), .req(req), .ack(ack),
        .valid(v_lr), .id(id_lr), .pending(p_lr));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; ack = 1'b0; En = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        do_reset();
        n_checks++; if (v_f !== 1'b0) $display("FAIL reset_valid: got %b want 0", v_f); else n_pass++;
        n_checks++; if (id_f !== 4'd0) $display("FAIL reset_id: got %0d want 0", id_f); else n_pass++;
        n_checks++; if (p_f !== 16'h0000) $display("FAIL reset_pending: got %h want 0000", p_f); else n_pass++;
        req = 16'h0020;
        exp_q.push_back(4'd5);
        tick();
        req = '0;
        n_checks++; if (p_f !== 16'h0020) $display("FAIL edge_capture: got %h want 0020", p_f); else n_pass++;
        n_checks++; if (v_f !== 1'b0) $display("FAIL early_valid: got %b want 0", v_f); else n_pass++;
        tick();
        n_checks++; if (v_f !== 1'b1) $display("FAIL grant_valid: got %b want 1", v_f); else n_pass++;
        e = exp_q.pop_front();
        n_checks++; if (id_f !== e) $display("FAIL grant_id: got %0d want %0d", id_f, e); else n_pass++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++; if (v_f !== 1'b0) $display("FAIL ack_valid: got %b want 0", v_f); else n_pass++;
        n_checks++; if (p_f !== 16'h0000) $display("FAIL ack_clear: got %h want 0000", p_f); else n_pass++;
    endtask

    task automatic test_fixed();
        logic [3:0] e;
        int cycles = 0;
        do_reset();
        req = 16'h0209;
        exp_q.push_back(4'd0); exp_q.push_back(4'd3); exp_q.push_back(4'd9);
        tick();
        req = '0;
        while (exp_q.size() > 0 && cycles < 20) begin
            tick(); cycles++;
            if (v_f) begin
                e = exp_q.pop_front();
                n_checks++; if (id_f !== e) $display("FAIL fixed_id: got %0d want %0d", id_f, e); else n_pass++;
                ack = 1'b1; tick(); ack = 1'b0; cycles++;
                n_checks++; if (v_f !== 1'b0) $display("FAIL fixed_gap: got valid %b want 0", v_f); else n_pass++;
            end
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL fixed_timeout: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_rr_alternate();
        logic [3:0] e;
        int cycles = 0;
        do_reset();
        req = 16'h0084;
        exp_q.push_back(4'd2); exp_q.push_back(4'd7); exp_q.push_back(4'd2); exp_q.push_back(4'd7);
        while (exp_q.size() > 0 && cycles < 30) begin
            tick(); cycles++;
            if (v_lr) begin
                e = exp_q.pop_front();
                n_checks++; if (id_lr !== e) $display("FAIL rr_alt_id: got %0d want %0d", id_lr, e); else n_pass++;
                ack = 1'b1; tick(); ack = 1'b0; cycles++;
            end
        end
        req = '0;
        n_checks++; if (exp_q.size() != 0) $display("FAIL rr_alt_timeout: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_rr_wrap();
        logic [3:0]  e;
        logic [15:0] masks[2];
        int cycles = 0;
        masks[0] = 16'h4000;
        masks[1] = 16'h8003;
        do_reset();
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 0) begin
                exp_q.push_back(4'd14);
            end else begin
                exp_q.push_back(4'd15); exp_q.push_back(4'd0); exp_q.push_back(4'd1);
            end
            req = masks[ph];
            tick();
            req = '0;
            while (exp_q.size() > 0 && cycles < 40) begin
                tick(); cycles++;
                if (v_r) begin
                    e = exp_q.pop_front();
                    n_checks++; if (id_r !== e) $display("FAIL rr_wrap_id: got %0d want %0d", id_r, e); else n_pass++;
                    ack = 1'b1; tick(); ack = 1'b0; cycles++;
                end
            end
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL rr_wrap_timeout: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_collision();
        logic [3:0] e;
        do_reset();
        req = 16'h0010;
        exp_q.push_back(4'd4); exp_q.push_back(4'd4);
        tick();
        tick();
        e = exp_q.pop_front();
        n_checks++; if (v_l !== 1'b1 || id_l !== e) $display("FAIL level_grant: got v=%b id=%0d want v=1 id=%0d", v_l, id_l, e); else n_pass++;
        ack = 1'b1; tick(); ack = 1'b0;
        n_checks++; if (v_l !== 1'b0) $display("FAIL level_ack_valid: got %b want 0", v_l); else n_pass++;
        n_checks++; if (p_l !== 16'h0010) $display("FAIL set_wins: got %h want 0010", p_l); else n_pass++;
        tick();
        e = exp_q.pop_front();
        n_checks++; if (v_l !== 1'b1 || id_l !== e) $display("FAIL level_regrant: got v=%b id=%0d want v=1 id=%0d", v_l, id_l, e); else n_pass++;
        req = '0;
    endtask

    task automatic test_en_stray();
        do_reset();
        En = 1'b0;
        req = 16'h0100;
        tick();
        req = '0;
        for (int k = 0; k < 3; k++) begin
            ack = 1'b1; tick(); ack = 1'b0;
            n_checks++; if (v_f !== 1'b0 || p_f !== 16'h0100) $display("FAIL en_block: got v=%b p=%h want v=0 p=0100", v_f, p_f); else n_pass++;
        end
        En = 1'b1;
        tick();
        n_checks++; if (v_f !== 1'b1 || id_f !== 4'd8) $display("FAIL en_grant: got v=%b id=%0d want v=1 id=8", v_f, id_f); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        do_reset();
        req = 16'h0040;
        tick();
        req = '0;
        tick();
        req = 16'h0001;
        tick();
        req = '0;
        n_checks++; if (v_f !== 1'b1 || id_f !== 4'd6 || p_f !== 16'h0041) $display("FAIL hold_grant: got v=%b id=%0d p=%h want v=1 id=6 p=0041", v_f, id_f, p_f); else n_pass++;
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++; if (v_f !== 1'b0 || id_f !== 4'd0 || p_f !== 16'h0000) $display("FAIL mid_reset: got v=%b id=%0d p=%h want v=0 id=0 p=0000", v_f, id_f, p_f); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (v_f) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL post_reset_grant: got %0d grants want 0", seen); else n_pass++;
        rst = 1'b1; req = 16'h0004; tick(); rst = 1'b0;
        n_checks++; if (p_f !== 16'h0000) $display("FAIL held_in_reset: got %h want 0000", p_f); else n_pass++;
        tick();
        n_checks++; if (p_f !== 16'h0004) $display("FAIL release_edge: got %h want 0004", p_f); else n_pass++;
        tick();
        n_checks++; if (v_f !== 1'b1 || id_f !== 4'd2) $display("FAIL release_grant: got v=%b id=%0d want v=1 id=2", v_f, id_f); else n_pass++;
        req = '0;
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_alternate();
        test_rr_wrap();
        test_collision();
        test_en_stray();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
